// File: rtl/ball_motion_if.sv
// ball_motion_if: control inputs and ball position/status outputs of ball_motion.
interface ball_motion_if #(
  parameter int BALL_X_W = 10,
  parameter int BALL_Y_W = 10
);
  logic                frame_tick;
  logic                serve;
  logic [BALL_Y_W-1:0] paddle1_y;
  logic [BALL_Y_W-1:0] paddle2_y;
  logic [BALL_X_W-1:0] ball_x_coords;
  logic [BALL_Y_W-1:0] ball_y_coords;
  logic                in_play;
  logic                paddle_hit;
  modport master (
    output frame_tick, serve, paddle1_y, paddle2_y,
    input  ball_x_coords, ball_y_coords, in_play, paddle_hit
  );
  modport slave (
    input  frame_tick, serve, paddle1_y, paddle2_y,
    output ball_x_coords, ball_y_coords, in_play, paddle_hit
  );
endinterface

// File: rtl/ball_motion.sv
// ball_motion: pong ball serve/move/reflect/miss generator feeding the score manager.
// Optional BALL_SPEEDUP_EN: each paddle hit raises the x step by one, capped at MAX_SPEED.
module ball_motion #(
  parameter int BALL_X_W  = 10,
  parameter int BALL_Y_W  = 10,
  parameter int X_MIN     = 50,
  parameter int X_MAX     = 600,
  parameter int PAD1_X    = 60,
  parameter int PAD2_X    = 590,
  parameter int PAD_H     = 48,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_START   = 325,
  parameter int Y_START   = 240,
  parameter int SPEED     = 2,
  parameter int Y_SPEED   = 1,
  parameter int MAX_SPEED = 6
) (
  input logic          clk,
  input logic          reset,
  ball_motion_if.slave bus
);
  localparam int XW = BALL_X_W + 2;
  localparam int YW = BALL_Y_W + 2;
  localparam int STEP0 = (SPEED > MAX_SPEED) ? MAX_SPEED : SPEED;
  typedef logic signed [XW-1:0] sx_t;
  typedef logic signed [YW-1:0] sy_t;
  typedef enum logic [1:0] {IDLE, MOVE, OUT} state_t;
  localparam sx_t XMIN_S = sx_t'(X_MIN);
  localparam sx_t XMAX_S = sx_t'(X_MAX);
  localparam sx_t PAD1_S = sx_t'(PAD1_X);
  localparam sx_t PAD2_S = sx_t'(PAD2_X);
  localparam sy_t YMIN_S = sy_t'(Y_MIN);
  localparam sy_t YMAX_S = sy_t'(Y_MAX);
  localparam logic [BALL_X_W-1:0] XSTART = BALL_X_W'(X_START);
  localparam logic [BALL_Y_W-1:0] YSTART = BALL_Y_W'(Y_START);
  state_t state_q, state_d;
  logic [BALL_X_W-1:0] x_q, x_d;
  logic [BALL_Y_W-1:0] y_q, y_d;
  logic x_dir_q, x_dir_d, y_dir_q, y_dir_d, serve_dir_q, serve_dir_d, hit_q, hit_d;
  sx_t step, cx, nx;
  sy_t cy, ny, p1, p2;
  logic in1, in2, hit1, hit2, go;
  // Signed, two-bit-wider arithmetic so a step past 0 or past the top of the range is seen as such.
  assign cx   = $signed({2'b00, x_q});
  assign cy   = $signed({2'b00, y_q});
  assign p1   = $signed({2'b00, bus.paddle1_y});
  assign p2   = $signed({2'b00, bus.paddle2_y});
  assign nx   = x_dir_q ? cx + step : cx - step;
  assign ny   = y_dir_q ? cy + sy_t'(Y_SPEED) : cy - sy_t'(Y_SPEED);
  assign in1  = cy >= p1 && cy <= p1 + sy_t'(PAD_H - 1);
  assign in2  = cy >= p2 && cy <= p2 + sy_t'(PAD_H - 1);
  assign hit1 = !x_dir_q && cx > PAD1_S && nx <= PAD1_S && in1;
  assign hit2 = x_dir_q && cx < PAD2_S && nx >= PAD2_S && in2;
  assign go   = state_q == IDLE && bus.serve;
`ifdef BALL_SPEEDUP_EN
  localparam sx_t MAX_S = sx_t'(MAX_SPEED);
  sx_t step_q, step_d;
  assign step_d = go ? sx_t'(STEP0) : (hit_d && step_q < MAX_S) ? step_q + sx_t'(1) : step_q;
  assign step   = step_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) step_q <= sx_t'(STEP0);
    else        step_q <= step_d;
`else
  assign step = sx_t'(STEP0);
`endif
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    x_dir_d     = x_dir_q;
    y_dir_d     = y_dir_q;
    serve_dir_d = serve_dir_q;
    hit_d       = 1'b0;
    case (state_q)
      IDLE: begin
        x_d = XSTART;
        y_d = YSTART;
        if (go) begin
          state_d     = MOVE;
          x_dir_d     = serve_dir_q;
          y_dir_d     = 1'b1;
          serve_dir_d = ~serve_dir_q;
        end
      end
      MOVE: if (bus.frame_tick) begin
        y_d     = ny < YMIN_S ? BALL_Y_W'(Y_MIN) : ny > YMAX_S ? BALL_Y_W'(Y_MAX) : ny[BALL_Y_W-1:0];
        y_dir_d = ny < YMIN_S ? 1'b1 : ny > YMAX_S ? 1'b0 : y_dir_q;
        if (hit1) begin
          x_d     = BALL_X_W'(PAD1_X + 1);
          x_dir_d = 1'b1;
          hit_d   = 1'b1;
        end else if (hit2) begin
          x_d     = BALL_X_W'(PAD2_X - 1);
          x_dir_d = 1'b0;
          hit_d   = 1'b1;
        end else if (nx < XMIN_S) begin
          x_d     = BALL_X_W'(X_MIN - 1);
          state_d = OUT;
        end else if (nx > XMAX_S) begin
          x_d     = BALL_X_W'(X_MAX + 1);
          state_d = OUT;
        end else begin
          x_d = nx[BALL_X_W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = XSTART;
        y_d     = YSTART;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= XSTART;
      y_q         <= YSTART;
      x_dir_q     <= 1'b1;
      y_dir_q     <= 1'b1;
      serve_dir_q <= 1'b1;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_dir_q     <= x_dir_d;
      y_dir_q     <= y_dir_d;
      serve_dir_q <= serve_dir_d;
      hit_q       <= hit_d;
    end
  assign bus.ball_x_coords = x_q;
  assign bus.ball_y_coords = y_q;
  assign bus.in_play       = state_q == MOVE;
  assign bus.paddle_hit    = hit_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed vectors with hand-computed positions for ball_motion.
module tb_ball_motion;
`ifdef BALL_SPEEDUP_EN
  localparam int S2 = 3;
`else
  localparam int S2 = 2;
`endif
  logic clk = 1'b0;
  logic reset;
  int n_pass = 0, n_total = 0, out_cnt = 0, base;
  ball_motion_if bus ();
  ball_motion dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.ball_x_coords > 10'd600) out_cnt <= out_cnt + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick(input int n);
    @(negedge clk) bus.frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask
  task automatic do_serve();
    @(negedge clk) bus.serve = 1'b1;
    @(negedge clk) bus.serve = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask
  task automatic pos(input string tag, input int ex, input int ey);
    check({tag, "_x"}, int'(bus.ball_x_coords), ex);
    check({tag, "_y"}, int'(bus.ball_y_coords), ey);
  endtask
  initial begin
    reset = 1'b0;
    bus.frame_tick = 1'b0;
    bus.serve = 1'b0;
    bus.paddle1_y = '0;
    bus.paddle2_y = '0;
    repeat (2) @(negedge clk);
    pos("rst", 325, 240);
    check("rst_play", int'(bus.in_play), 0);
    check("rst_hit", int'(bus.paddle_hit), 0);
    reset = 1'b1;
    tick(3);
    pos("idle_hold", 325, 240);
    do_serve();
    check("serve_play", int'(bus.in_play), 1);
    tick(10);
    pos("ten_ticks", 345, 250);
    check("ten_play", int'(bus.in_play), 1);
    repeat (10) @(negedge clk);
    pos("no_tick", 345, 250);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 pos("async_rst", 325, 240);
    check("async_rst_play", int'(bus.in_play), 0);
    @(negedge clk) reset = 1'b1;
    do_serve();
    tick(1);
    pos("reserve_right", 327, 241);
    do_reset();
    bus.paddle2_y = 10'd362;
    do_serve();
    tick(133);
    pos("p2_hit", 589, 373);
    check("p2_hit_pulse", int'(bus.paddle_hit), 1);
    @(negedge clk);
    check("p2_hit_end", int'(bus.paddle_hit), 0);
    check("p2_hold_x", int'(bus.ball_x_coords), 589);
    tick(1);
    pos("after_hit", 589 - S2, 374);
    tick(105);
    pos("at_wall", 589 - 106 * S2, 479);
    tick(1);
    pos("wall_hold", 589 - 107 * S2, 479);
    tick(1);
    pos("wall_up", 589 - 108 * S2, 478);
    bus.serve = 1'b1;
    tick(1);
    bus.serve = 1'b0;
    pos("serve_in_move", 589 - 109 * S2, 477);
    check("serve_in_move_play", int'(bus.in_play), 1);
    do_reset();
    bus.paddle2_y = '0;
    base = out_cnt;
    do_serve();
    tick(137);
    check("miss_pass_x", int'(bus.ball_x_coords), 599);
    check("miss_pass_play", int'(bus.in_play), 1);
    tick(1);
    pos("out", 601, 378);
    check("out_play", int'(bus.in_play), 0);
    @(negedge clk);
    pos("recentre", 325, 240);
    check("recentre_play", int'(bus.in_play), 0);
    check("out_one_clock", out_cnt - base, 1);
    do_serve();
    tick(1);
    pos("serve_left", 323, 241);
    do_reset();
    @(negedge clk);
    bus.serve = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.serve = 1'b0;
    bus.frame_tick = 1'b0;
    pos("tick_on_serve", 325, 240);
    check("tick_on_serve_play", int'(bus.in_play), 1);
    tick(1);
    pos("first_step", 327, 241);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
